// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared FSM encodings and expected truth tables
//
// Purpose: state encodings for the sweeper FSM and the expected truth tables
// (bit k = Z for input vector k, {A,B,C} with A as MSB) of the team's
// 3-input gate circuits.
// Ports: none (package).

package truth_table_sweeper_pkg;

  typedef logic [1:0] sweep_state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Expected tables for the 3-input gate circuits.
  localparam logic [7:0] TT_AB_XOR_NBC = 8'hB7;  // (A&B) ^ ~(B&C)
  localparam logic [7:0] TT_MAJ3       = 8'hE8;  // majority(A,B,C)
  localparam logic [7:0] TT_XOR3       = 8'h96;  // A ^ B ^ C
  localparam logic [7:0] TT_AND3       = 8'h80;  // A & B & C
  localparam logic [7:0] TT_OR3        = 8'hFE;  // A | B | C

  // State entered after a vector is driven: with no settle time the
  // sample cycle follows the drive edge directly.
  function automatic sweep_state_t settle_entry(input int settle);
    return (settle == 0) ? ST_SAMPLE : ST_SETTLE;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// rtl/truth_table_sweeper_settle_timer.sv - loadable settle down-counter with zero flag
//
// Purpose: counts the idle settle cycles between driving a vector and the
// sample cycle.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   i_load  in   reload the counter
//   i_dec   in   decrement (stops at zero)
//   o_zero  out  counter reads zero

module sweep_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // Loaded with SETTLE-1: the FSM leaves SETTLE on the edge where the count
  // already reads zero, so SETTLE cycles are spent in total.
  localparam logic [CW-1:0] LOAD_VAL = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive stimulus and truth-table capture for a gate circuit
//
// Purpose: drives every input vector in ascending order, waits SETTLE
// cycles, samples z_in, builds the observed table and compares it to
// EXPECTED.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   sweep request (honoured in IDLE and DONE only)
//   z_in          in   output of the circuit under test
//   abc_out       out  current input vector
//   busy          out  sweep in progress
//   done          out  sweep complete, until next start or reset
//   table_out     out  captured truth table
//   mismatch_cnt  out  entries that differ from EXPECTED
//   first_fail    out  lowest mismatching index (valid when mismatch_cnt != 0)
//   pass          out  done with zero mismatches

module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                    N_IN     = 3,
  parameter int                    SETTLE   = 2,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = TT_AB_XOR_NBC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   z_in,
  output logic [N_IN-1:0]        abc_out,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_out,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_fail,
  output logic                   pass
);

  localparam int              NT       = 2**N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  sweep_state_t        r_state;
  logic [N_IN-1:0]     r_idx;
  logic [NT-1:0]       r_table;
  logic [N_IN:0]       r_mis;
  logic [N_IN-1:0]     r_ff;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;

  logic                w_start_ok;
  logic                w_last;
  logic                w_miss;
  logic [N_IN:0]       w_mis_next;
  logic                w_timer_load;
  logic                w_timer_dec;
  logic                w_timer_zero;
  sweep_state_t        w_entry;

  assign w_entry      = settle_entry(SETTLE);
  assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last       = (r_idx == IDX_LAST);
  assign w_miss       = (z_in != EXPECTED[r_idx]);
  assign w_mis_next   = r_mis + {{N_IN{1'b0}}, w_miss};
  assign w_timer_load = w_start_ok || ((r_state == ST_SAMPLE) && !w_last);
  assign w_timer_dec  = (r_state == ST_SETTLE);

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_timer_load),
    .i_dec  (w_timer_dec),
    .o_zero (w_timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_table <= '0;
      r_mis   <= '0;
      r_ff    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= w_entry;
            r_idx   <= '0;
            r_table <= '0;
            r_mis   <= '0;
            r_ff    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_timer_zero) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_table[r_idx] <= z_in;
          if (w_miss) begin
            r_mis <= w_mis_next;
            if (r_mis == '0) begin
              r_ff <= r_idx;
            end
          end
          if (!w_last) begin
            r_idx   <= r_idx + 1'b1;
            r_state <= w_entry;
          end else begin
            // abc_out parks at 0 while the result is held.
            r_idx   <= '0;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_mis_next == '0);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign abc_out      = r_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign table_out    = r_table;
  assign mismatch_cnt = r_mis;
  assign first_fail   = r_ff;
  assign pass         = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper

module tb_truth_table_sweeper;

  typedef struct {
    int         mode;   // 0 golden circuit, 1 tied 0, 2 tied 1
    logic [7:0] tbl;
    int         cnt;
    int         ff;
    logic       pass;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   zmode = 0;
  bit   sel = 1'b0;

  logic [2:0] a_abc, b_abc, m_abc;
  logic       a_busy, b_busy, m_busy;
  logic       a_done, b_done, m_done;
  logic [7:0] a_tbl, b_tbl, m_tbl;
  logic [3:0] a_cnt, b_cnt, m_cnt;
  logic [2:0] a_ff, b_ff, m_ff;
  logic       a_pass, b_pass, m_pass;
  logic       z_a, z_b;

  vec_t vecs[3];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic circuit(input logic [2:0] v, input int mode);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return (v[2] & v[1]) ^ ~(v[1] & v[0]);
  endfunction

  assign z_a = circuit(a_abc, zmode);
  assign z_b = circuit(b_abc, zmode);

  truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hB7)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .z_in(z_a), .abc_out(a_abc),
    .busy(a_busy), .done(a_done), .table_out(a_tbl), .mismatch_cnt(a_cnt),
    .first_fail(a_ff), .pass(a_pass)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(0), .EXPECTED(8'hB7)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .z_in(z_b), .abc_out(b_abc),
    .busy(b_busy), .done(b_done), .table_out(b_tbl), .mismatch_cnt(b_cnt),
    .first_fail(b_ff), .pass(b_pass)
  );

  always_comb begin
    m_abc  = sel ? b_abc  : a_abc;
    m_busy = sel ? b_busy : a_busy;
    m_done = sel ? b_done : a_done;
    m_tbl  = sel ? b_tbl  : a_tbl;
    m_cnt  = sel ? b_cnt  : a_cnt;
    m_ff   = sel ? b_ff   : a_ff;
    m_pass = sel ? b_pass : a_pass;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_abc"},  m_abc,  0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_tbl"},  m_tbl,  0);
    chk({tag, "_cnt"},  m_cnt,  0);
    chk({tag, "_ff"},   m_ff,   0);
    chk({tag, "_pass"}, m_pass, 0);
  endtask

  // One sweep on the selected DUT. pulses: extra start pulses at t0+5 and
  // t0+20. hold: start stays high through and past completion.
  task automatic run_sweep(input vec_t v, input int period, input bit pulses, input bit hold);
    int   c;
    bit   seen;
    vec_t e;
    zmode = v.mode;
    sb.push_back(v);
    set_start(1'b1);
    tick();                                 // edge t0
    if (!hold) set_start(1'b0);
    chk("start_busy", m_busy, 1);
    chk("start_done", m_done, 0);
    chk("start_tbl",  m_tbl,  0);
    chk("start_cnt",  m_cnt,  0);
    chk("start_abc",  m_abc,  0);
    c = 0;
    seen = 1'b0;
    while (c < 200 && !seen) begin
      if (pulses) begin
        if (c == 4 || c == 19) set_start(1'b1);
        if (c == 5 || c == 20) set_start(1'b0);
      end
      tick();
      c++;
      if (m_done) seen = 1'b1;
      else        chk("abc_step", m_abc, c / period);
    end
    chk("done_time", seen ? c : -1, 8 * period);
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("table_out", m_tbl, e.tbl);
      chk("mismatch_cnt", m_cnt, e.cnt);
      if (e.cnt != 0) chk("first_fail", m_ff, e.ff);
      chk("pass", m_pass, e.pass);
    end
    chk("done_busy", m_busy, 0);
    chk("done_abc",  m_abc,  0);
    if (hold) begin
      tick();
      chk("done_one_cycle", m_done, 0);
      chk("restart_busy",   m_busy, 1);
      set_start(1'b0);
      c = 0;
      while (c < 200 && !m_done) begin
        tick();
        c++;
      end
      chk("drain_done", m_done, 1);
    end
  endtask

  initial begin
    vecs[0] = '{mode: 0, tbl: 8'hB7, cnt: 0, ff: 0, pass: 1'b1};
    vecs[1] = '{mode: 1, tbl: 8'h00, cnt: 6, ff: 0, pass: 1'b0};
    vecs[2] = '{mode: 2, tbl: 8'hFF, cnt: 2, ff: 3, pass: 1'b0};

    repeat (3) tick();
    check_all_zero("reset");
    chk("reset_b_busy", b_busy, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Golden, tied 0, tied 1 with the default settle time.
    for (int i = 0; i < 3; i++) run_sweep(vecs[i], 3, 1'b0, 1'b0);

    // Starts while busy are ignored; then start held high restarts once.
    run_sweep(vecs[0], 3, 1'b1, 1'b0);
    run_sweep(vecs[0], 3, 1'b0, 1'b1);

    // Asynchronous reset in the middle of vector 3.
    zmode = 0;
    tick();
    set_start(1'b1);
    tick();                                 // edge t0
    set_start(1'b0);
    repeat (10) tick();                     // edge t0+10, vector 3 on abc_out
    chk("pre_rst_abc", m_abc, 3);
    chk("pre_rst_tbl", m_tbl, 8'h07);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    #1;
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle_busy", m_busy, 0);
    chk("post_rst_idle_done", m_done, 0);
    run_sweep(vecs[0], 3, 1'b0, 1'b0);

    // SETTLE = 0 instance.
    sel = 1'b1;
    run_sweep(vecs[0], 1, 1'b0, 1'b0);
    run_sweep(vecs[2], 1, 1'b0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
